// File: rtl/csa_accum_if.sv
// Beat input and result output bundle for the carry-save accumulator.
interface csa_accum_if #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 20,
    parameter int MAX_BEATS = 16,
    parameter int CW        = $clog2(MAX_BEATS + 1)
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [WIDTH-1:0]     in_c;
    logic [WIDTH-1:0]     in_d;
    logic                 in_first;
    logic                 in_last;
    logic                 in_shift;
    logic                 in_sub;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_data;
    logic [CW-1:0]        out_count;
    logic                 err_restart;
    logic                 err_overrun;

    modport master (
        output in_valid, in_a, in_b, in_c, in_d,
        output in_first, in_last, in_shift, in_sub, out_ready,
        input  in_ready, out_valid, out_data, out_count,
        input  err_restart, err_overrun
    );

    modport slave (
        input  in_valid, in_a, in_b, in_c, in_d,
        input  in_first, in_last, in_shift, in_sub, out_ready,
        output in_ready, out_valid, out_data, out_count,
        output err_restart, err_overrun
    );
endinterface

// File: rtl/csa_accum_pipe.sv
// Carry-save accumulator with optional doubling/subtraction per beat and a
// single carry-propagate resolve stage in front of a valid/ready result.
module csa_accum_pipe #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 20,
    parameter int MAX_BEATS = 16
) (
    input logic        clk,
    input logic        rst,
    csa_accum_if.slave bus
);
    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam int EXT = ACC_WIDTH - WIDTH;

    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, HOLD} state_t;

    state_t               state;
    logic [ACC_WIDTH-1:0] acc_s;
    logic [ACC_WIDTH-1:0] acc_c;
    logic [CW-1:0]        cnt;
    logic [ACC_WIDTH-1:0] data_q;
    logic [CW-1:0]        count_q;
    logic                 valid_q;
    logic                 restart_q;
    logic                 overrun_q;

    logic                 take;
    logic                 start;
    logic                 ends;
    logic                 at_max;
    logic [CW-1:0]        cnt_next;
    logic [ACC_WIDTH-1:0] inv;
    logic [ACC_WIDTH-1:0] base_s, base_c;
    logic [ACC_WIDTH-1:0] op_s, op_c;
    logic [ACC_WIDTH-1:0] op_a, op_b, op_cc, op_d;
    logic [ACC_WIDTH-1:0] s1, c1, s2, c2, s3, c3, nx_s, nx_c;

    // 3:2 compressor; the vacated carry LSB carries the negation constant.
    function automatic logic [2*ACC_WIDTH-1:0] csa(
        input logic [ACC_WIDTH-1:0] x,
        input logic [ACC_WIDTH-1:0] y,
        input logic [ACC_WIDTH-1:0] z,
        input logic                 cin
    );
        logic [ACC_WIDTH-1:0] s;
        logic [ACC_WIDTH-1:0] m;
        s = x ^ y ^ z;
        m = (x & y) | (x & z) | (y & z);
        return {s, m[ACC_WIDTH-2:0], cin};
    endfunction

    assign bus.in_ready    = (state == IDLE) || (state == ACCUM);
    assign bus.out_valid   = valid_q;
    assign bus.out_data    = data_q;
    assign bus.out_count   = count_q;
    assign bus.err_restart = restart_q;
    assign bus.err_overrun = overrun_q;

    always_comb begin
        take     = bus.in_valid && bus.in_ready;
        start    = (state == IDLE) || bus.in_first;
        cnt_next = start ? CW'(1) : cnt + CW'(1);
        at_max   = (cnt_next == CW'(MAX_BEATS));
        ends     = bus.in_last || at_max;
        base_s   = start ? '0 : acc_s;
        base_c   = start ? '0 : acc_c;
        op_s     = bus.in_shift ? {base_s[ACC_WIDTH-2:0], 1'b0} : base_s;
        op_c     = bus.in_shift ? {base_c[ACC_WIDTH-2:0], 1'b0} : base_c;
        // Subtraction: -x = sum(~op) + 4, the 4 split over four carry LSBs.
        inv      = {ACC_WIDTH{bus.in_sub}};
        op_a     = inv ^ {{EXT{bus.in_a[WIDTH-1]}}, bus.in_a};
        op_b     = inv ^ {{EXT{bus.in_b[WIDTH-1]}}, bus.in_b};
        op_cc    = inv ^ {{EXT{bus.in_c[WIDTH-1]}}, bus.in_c};
        op_d     = inv ^ {{EXT{bus.in_d[WIDTH-1]}}, bus.in_d};
        {s1, c1}     = csa(op_s, op_c, op_a, bus.in_sub);
        {s2, c2}     = csa(op_b, op_cc, op_d, bus.in_sub);
        {s3, c3}     = csa(s1, c1, s2, bus.in_sub);
        {nx_s, nx_c} = csa(s3, c3, c2, bus.in_sub);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc_s     <= '0;
            acc_c     <= '0;
            cnt       <= '0;
            data_q    <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            restart_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            restart_q <= 1'b0;
            overrun_q <= 1'b0;
            unique case (state)
                IDLE, ACCUM: begin
                    if (take) begin
                        acc_s     <= nx_s;
                        acc_c     <= nx_c;
                        cnt       <= cnt_next;
                        restart_q <= (state == ACCUM) && bus.in_first;
                        overrun_q <= at_max && !bus.in_last && (MAX_BEATS > 1);
                        state     <= ends ? RESOLVE : ACCUM;
                    end
                end
                RESOLVE: begin
                    data_q  <= acc_s + acc_c;
                    count_q <= cnt;
                    valid_q <= 1'b1;
                    state   <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        acc_s   <= '0;
                        acc_c   <= '0;
                        cnt     <= '0;
                        state   <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_csa_accum_pipe.sv
// Directed-vector bench for csa_accum_pipe with a queue-based scoreboard.
module tb_csa_accum_pipe;
    localparam int W  = 16;
    localparam int AW = 20;
    localparam int MB = 16;
    localparam int CW = $clog2(MB + 1);

    typedef struct {
        logic [AW-1:0] data;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   n_restart = 0;
    int   n_overrun = 0;
    int   beats = 0;
    exp_t q[$];

    csa_accum_if #(.WIDTH(W), .ACC_WIDTH(AW), .MAX_BEATS(MB)) bus ();

    csa_accum_pipe #(.WIDTH(W), .ACC_WIDTH(AW), .MAX_BEATS(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic expect_res(input logic [AW-1:0] d, input logic [CW-1:0] c);
        exp_t e;
        e.data = d;
        e.cnt  = c;
        q.push_back(e);
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic [W-1:0] d,
                        input logic first, input logic last,
                        input logic shift, input logic sub);
        int n;
        n = 0;
        bus.in_a = a; bus.in_b = b; bus.in_c = c; bus.in_d = d;
        bus.in_first = first; bus.in_last = last;
        bus.in_shift = shift; bus.in_sub = sub;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=in_ready_low expected=accept");
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, q.size(), 0);
    endtask

    // Monitor: pops one expectation per completed output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.err_restart) n_restart++;
                if (bus.err_overrun) n_overrun++;
                if (bus.in_valid && bus.in_ready) beats++;
                if (bus.out_valid && bus.out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result actual=%0h expected=none",
                                 bus.out_data);
                    end else begin
                        e = q.pop_front();
                        check("out_data", bus.out_data, e.data);
                        check("out_count", bus.out_count, e.cnt);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   b0;
        int   n;
        bus.in_valid = 1'b0;
        bus.in_a = '0; bus.in_b = '0; bus.in_c = '0; bus.in_d = '0;
        bus.in_first = 1'b0; bus.in_last = 1'b0;
        bus.in_shift = 1'b0; bus.in_sub = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_count", bus.out_count, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_err", {bus.err_restart, bus.err_overrun}, 0);

        // Single beat: 1+2+3+4, latency check.
        expect_res(20'd10, 5'd1);
        send(16'd1, 16'd2, 16'd3, 16'd4, 1, 1, 0, 0);
        check("lat_edge1_valid", bus.out_valid, 0);
        @(posedge clk); #1;
        check("lat_edge2_valid", bus.out_valid, 1);
        drain("drain_single");

        // Four beats of all -1 operands.
        expect_res(20'hFFFF0, 5'd4);
        for (int i = 0; i < 4; i++)
            send(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, i == 0, i == 3, 0, 0);
        drain("drain_neg");

        // DA mode: -1, then 2*(-1)+1, then 2*(-1).
        expect_res(20'hFFFFE, 5'd3);
        send(16'd1, 16'd0, 16'd0, 16'd0, 1, 0, 0, 1);
        send(16'd1, 16'd0, 16'd0, 16'd0, 0, 0, 1, 0);
        send(16'd0, 16'd0, 16'd0, 16'd0, 0, 1, 1, 0);
        drain("drain_da");

        // Back-pressure: result held while a beat waits.
        bus.out_ready = 1'b0;
        expect_res(20'd100, 5'd1);
        send(16'd100, 16'd0, 16'd0, 16'd0, 1, 1, 0, 0);
        expect_res(20'd3, 5'd1);
        bus.in_a = 16'd3; bus.in_b = '0; bus.in_c = '0; bus.in_d = '0;
        bus.in_first = 1'b1; bus.in_last = 1'b1;
        bus.in_shift = 1'b0; bus.in_sub = 1'b0;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        b0 = beats;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_in_ready", bus.in_ready, 0);
            check("hold_out_valid", bus.out_valid, 1);
            check("hold_out_data", bus.out_data, 100);
        end
        check("hold_no_beats", beats, b0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("after_hs_in_ready", bus.in_ready, 1);
        check("after_hs_out_valid", bus.out_valid, 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        drain("drain_hold");

        // Restart inside ACCUM.
        expect_res(20'd7, 5'd1);
        send(16'd5, 16'd0, 16'd0, 16'd0, 1, 0, 0, 0);
        send(16'd5, 16'd0, 16'd0, 16'd0, 0, 0, 0, 0);
        send(16'd7, 16'd0, 16'd0, 16'd0, 1, 1, 0, 0);
        drain("drain_restart");
        check("err_restart_pulses", n_restart, 1);
        check("err_overrun_none", n_overrun, 0);

        // Overrun: sixteen beats without last.
        expect_res(20'd16, 5'd16);
        for (int i = 0; i < 16; i++)
            send(16'd1, 16'd0, 16'd0, 16'd0, i == 0, 0, 0, 0);
        drain("drain_overrun");
        check("err_overrun_pulses", n_overrun, 1);
        check("err_restart_still", n_restart, 1);

        // Reset mid-ACCUM.
        for (int i = 0; i < 3; i++)
            send(16'd2, 16'd0, 16'd0, 16'd0, i == 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_out_data", bus.out_data, 0);
        check("mid_rst_out_count", bus.out_count, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_err", {bus.err_restart, bus.err_overrun}, 0);
        expect_res(20'd9, 5'd1);
        send(16'd9, 16'd0, 16'd0, 16'd0, 0, 1, 0, 0);
        drain("drain_post_rst");

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
